prbs4_checker: RTL and testbench

- Receive-side partner of the 4-bit LFSR random generator (polynomial x^4+x^3, successor = {v[2:0], v[3]^v[2]}).
- Samples the generator's 4-bit output on a valid strobe and self-synchronises to the sequence.
- Flags mismatches and keeps a saturating error count.
- Used on board to check generator output or a looped-back link carrying it.

---
 rtl/prbs4_pkg.sv | 18 +
 rtl/prbs4_checker_sat_counter.sv | 39 +++
 rtl/prbs4_checker.sv | 156 +++++++++++++++
 tb/tb_prbs4_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs4_pkg.sv
// prbs4_pkg: shared definitions for the 4-bit PRBS generator and checker.
//   SEED        - power-up seed of the generator (first value it emits)
//   chk_state_e - checker synchronisation state
//   prbs4_succ  - successor function of the x^4+x^3 LFSR, used by both ends
package prbs4_pkg;

  localparam logic [3:0] SEED = 4'd13;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  function automatic logic [3:0] prbs4_succ(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

endpackage

// File: rtl/prbs4_checker_sat_counter.sv
// prbs4_checker_sat_counter: W-bit up counter that sticks at all-ones.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears the count
//   inc_i   - add one (ignored once saturated)
//   clr_i   - synchronous clear, has priority over inc_i
//   count_o - current count
module prbs4_checker_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs4_checker.sv
// prbs4_checker: receive-side checker for the 4-bit x^4+x^3 PRBS generator.
// Self-synchronises to the incoming sequence, flags mismatches while locked
// and keeps a saturating error count.
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   rnd_in    - sampled generator value
//   rnd_valid - rnd_in is valid this cycle
//   err_clr   - synchronous clear of err_count
//   locked    - checker is synchronised to the sequence
//   err_pulse - one-cycle pulse for a mismatch seen while locked
//   err_count - saturating mismatch count
//   exp_out   - value predicted for the next sample (0 when nothing to predict)
//
// Handshake: rnd_valid is a one-cycle strobe with no back-pressure; the
// checker accepts every strobed sample, and all outputs reflect it on the
// following cycle. Cycles without rnd_valid leave the sync state untouched.
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       rnd_in,
  input  logic             rnd_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       exp_out
);

  // Run counters only need to reach LOCK_CNT-1 / LOSS_CNT-1: the step that
  // would hit the threshold changes state and zeroes the counter instead.
  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

  chk_state_e         state_q, state_d;
  logic [3:0]         prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [MATCH_W-1:0] match_run_q, match_run_d;
  logic [MISS_W-1:0]  miss_run_q, miss_run_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [3:0]         exp_out_q, exp_out_d;
  logic [3:0]         succ_prev;
  logic               sample_ok;
  logic               err_hit;

  assign succ_prev = prbs4_succ(prev_q);
  assign sample_ok = (rnd_in == succ_prev);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      exp_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      exp_out_q   <= exp_out_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_hit     = 1'b0;
    if (rnd_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (rnd_in == 4'd0) begin
            // Zero is never produced by a running LFSR: treat it as an idle
            // or reset generator and forget the previous sample.
            match_run_d = '0;
            have_prev_d = 1'b0;
          end else begin
            prev_d      = rnd_in;
            have_prev_d = 1'b1;
            if (have_prev_q && sample_ok) begin
              if (match_run_q == MATCH_LAST) begin
                state_d     = LOCKED;
                match_run_d = '0;
                miss_run_d  = '0;
              end else begin
                match_run_d = match_run_q + 1'b1;
              end
            end else begin
              match_run_d = '0;
            end
          end
        end
        LOCKED: begin
          if (sample_ok) begin
            prev_d     = rnd_in;
            miss_run_d = '0;
          end else begin
            err_hit = 1'b1;
            // Flywheel on our own prediction so one corrupted sample costs
            // one error rather than two.
            prev_d  = succ_prev;
            if (miss_run_q == MISS_LAST) begin
              state_d     = SEARCH;
              have_prev_d = 1'b0;
              match_run_d = '0;
              miss_run_d  = '0;
            end else begin
              miss_run_d = miss_run_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output logic (registered through the state register above)
  always_comb begin
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_hit;
    exp_out_d   = have_prev_d ? prbs4_succ(prev_d) : 4'd0;
  end

  prbs4_checker_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (err_hit),
    .clr_i  (err_clr),
    .count_o(err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign exp_out   = exp_out_q;

endmodule

// File: tb/tb_prbs4_checker.sv
module tb_prbs4_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int W        = 22;  // {locked, err_pulse, err_count[15:0], exp_out[3:0]}

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  rnd_in;
  logic        rnd_valid;
  logic        err_clr;

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [3:0]  exp_out;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
  logic [3:0]  exp_out4;

  always #5 clock = ~clock;

  prbs4_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .exp_out(exp_out)
  );

  prbs4_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .err_clr(err_clr), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .exp_out(exp_out4)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic compare_out(input string tag);
    logic [W-1:0] w;
    logic [3:0]   c4;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    w  = exp_q.pop_front();
    c4 = (w[19:4] > 16'd15) ? 4'd15 : w[7:4];
    chk({tag, " locked"},    16'(locked),     16'(w[21]));
    chk({tag, " err_pulse"}, 16'(err_pulse),  16'(w[20]));
    chk({tag, " err_count"}, err_count,       w[19:4]);
    chk({tag, " exp_out"},   16'(exp_out),    16'(w[3:0]));
    chk({tag, " locked4"},   16'(locked4),    16'(w[21]));
    chk({tag, " pulse4"},    16'(err_pulse4), 16'(w[20]));
    chk({tag, " count4"},    16'(err_count4), 16'(c4));
    chk({tag, " exp4"},      16'(exp_out4),   16'(w[3:0]));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] tb_succ(input logic [3:0] v);
    // x^4+x^3: shift left, new LSB = bit3 xor bit2
    logic [3:0] r;
    r[3] = v[2];
    r[2] = v[1];
    r[1] = v[0];
    r[0] = v[3] ^ v[2];
    return r;
  endfunction

  logic       m_locked, m_have, m_pulse;
  logic [3:0] m_prev;
  int         m_match, m_miss, m_cnt;

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_pulse = 0; m_prev = 0;
    m_match = 0; m_miss = 0; m_cnt = 0;
  endtask

  task automatic model_valid(input logic [3:0] v, input logic clr);
    logic [3:0] want;
    want    = tb_succ(m_prev);
    m_pulse = 0;
    if (!m_locked) begin
      if (v == 4'd0) begin
        m_match = 0;
        m_have  = 0;
      end else begin
        if (m_have && v == want) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_locked = 1; m_match = 0; m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
        m_prev = v;
        m_have = 1;
      end
    end else if (v == want) begin
      m_prev = v;
      m_miss = 0;
    end else begin
      m_pulse = 1;
      m_cnt++;
      m_prev = want;
      m_miss++;
      if (m_miss == LOSS_CNT) begin
        m_locked = 0; m_have = 0; m_match = 0; m_miss = 0;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [15:0] c;
    c = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
    return {m_locked, m_pulse, c, (m_have ? tb_succ(m_prev) : 4'd0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic vld, input logic [3:0] v, input logic clr,
                       input logic [W-1:0] want, input string tag);
    @(negedge clock);
    rnd_valid = vld;
    rnd_in    = v;
    err_clr   = clr;
    exp_q.push_back(want);
    @(posedge clock);
    #1;
    rnd_valid = 1'b0;
    err_clr   = 1'b0;
    compare_out(tag);
  endtask

  task automatic m_strobe(input logic [3:0] v, input logic clr, input string tag);
    model_valid(v, clr);
    cycle(1'b1, v, clr, pack_model(), tag);
  endtask

  task automatic m_idle(input int n, input logic clr, input string tag);
    for (int i = 0; i < n; i++) begin
      if (clr) m_cnt = 0;
      m_pulse = 0;
      cycle(1'b0, 4'($urandom_range(0, 15)), clr, pack_model(), tag);
    end
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back('0);
    compare_out(tag);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  v;
    logic        lk;
    logic        pu;
    logic [15:0] cnt;
    logic [3:0]  ex;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int v, input int lk, input int pu, input int cnt, input int ex);
    vec_t r;
    r.v = 4'(v); r.lk = 1'(lk); r.pu = 1'(pu); r.cnt = 16'(cnt); r.ex = 4'(ex);
    return r;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [3:0] g;
    logic [3:0] badv;

    // acquisition, single error, loss of lock, resync
    tbl[0]  = mk(13, 0, 0, 0, 10);
    tbl[1]  = mk(10, 0, 0, 0, 5);
    tbl[2]  = mk(5,  0, 0, 0, 11);
    tbl[3]  = mk(11, 0, 0, 0, 7);
    tbl[4]  = mk(7,  1, 0, 0, 15);
    tbl[5]  = mk(15, 1, 0, 0, 14);
    tbl[6]  = mk(3,  1, 1, 1, 12);
    tbl[7]  = mk(12, 1, 0, 1, 8);
    tbl[8]  = mk(8,  1, 0, 1, 1);
    tbl[9]  = mk(0,  1, 1, 2, 2);
    tbl[10] = mk(0,  1, 1, 3, 4);
    tbl[11] = mk(0,  0, 1, 4, 0);
    tbl[12] = mk(1,  0, 0, 4, 2);
    tbl[13] = mk(2,  0, 0, 4, 4);
    tbl[14] = mk(4,  0, 0, 4, 9);
    tbl[15] = mk(9,  0, 0, 4, 3);
    tbl[16] = mk(3,  1, 0, 4, 6);

    reset     = 1'b0;
    rnd_valid = 1'b0;
    rnd_in    = 4'd0;
    err_clr   = 1'b0;
    model_reset();

    // strobes while reset is held have no effect
    cycle(1'b1, 4'd13, 1'b0, '0, "rst_hold0");
    cycle(1'b1, 4'd10, 1'b0, '0, "rst_hold1");
    cycle(1'b1, 4'd5,  1'b1, '0, "rst_hold2");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, tbl[i].v, 1'b0, {tbl[i].lk, tbl[i].pu, tbl[i].cnt, tbl[i].ex},
            $sformatf("vec%0d", i));
    end

    // err_clr on an idle cycle clears the count, lock and prediction kept
    cycle(1'b0, 4'd7, 1'b1, {1'b1, 1'b0, 16'd0, 4'd6}, "clr_idle");

    // async reset while locked
    do_reset("async_rst_locked");

    // saturation: 20 isolated errors, each followed by a good sample
    m_strobe(4'd13, 1'b0, "sat_acq");
    m_strobe(4'd10, 1'b0, "sat_acq");
    m_strobe(4'd5,  1'b0, "sat_acq");
    m_strobe(4'd11, 1'b0, "sat_acq");
    m_strobe(4'd7,  1'b0, "sat_acq");
    g = 4'd7;
    for (int i = 0; i < 20; i++) begin
      badv = tb_succ(g) ^ 4'($urandom_range(1, 15));
      m_strobe(badv, 1'b0, "sat_bad");
      g = tb_succ(tb_succ(g));
      m_strobe(g, 1'b0, "sat_good");
    end
    chk("sat_count4", 16'(err_count4), 16'd15);
    chk("sat_count16", err_count, 16'd20);
    chk("sat_locked", 16'(locked), 16'd1);

    // err_clr coincident with a counted error: clear wins, pulse still fires
    badv = tb_succ(g) ^ 4'd5;
    m_strobe(badv, 1'b1, "clr_vs_err");
    chk("clr_vs_err pulse", 16'(err_pulse), 16'd1);
    chk("clr_vs_err count", err_count, 16'd0);
    g = tb_succ(g);
    m_strobe(tb_succ(g), 1'b0, "after_clr_good");
    g = tb_succ(g);
    m_strobe(g, 1'b0, "after_clr_repeat");  // repeated value is a mismatch
    chk("repeat count", err_count, 16'd1);

    // leading zeros then the sequence with random idle gaps
    do_reset("async_rst_gap");
    m_strobe(4'd0, 1'b0, "lead_zero");
    m_strobe(4'd0, 1'b0, "lead_zero");
    m_strobe(4'd0, 1'b0, "lead_zero");
    g = prbs4_pkg::SEED;
    for (int i = 0; i < 8; i++) begin
      m_strobe(g, 1'b0, $sformatf("gap_seq%0d", i));
      m_idle(int'($urandom_range(0, 50)), 1'b0, "gap_idle");
      g = tb_succ(g);
    end
    chk("gap_locked", 16'(locked), 16'd1);
    chk("gap_count", err_count, 16'd0);

    // reset in the middle of the sequence, then reacquire from scratch
    do_reset("async_rst_mid");
    for (int i = 0; i < 6; i++) begin
      m_strobe(g, 1'b0, "reacq");
      g = tb_succ(g);
    end
    chk("reacq_locked", 16'(locked), 16'd1);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
